fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_sequencer.sv | 154 +++++++++++++++
 tb/tb_fetch_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: drives PC/MAR/memory strobes, latches opcode and
// operand bytes, hands off to the execute unit, and traps on HLT or memory timeout.
module fetch_sequencer #(
  parameter int pMEM_WAIT_LIMIT = 15
) (
  input  logic        inCLK,
  input  logic        inRST,
  input  logic        inRun,
  input  logic        inMemReady,
  input  logic [7:0]  inWbus,
  input  logic [1:0]  inOpBytes,
  input  logic        inHaltOp,
  input  logic        inExecDone,
  output logic        outEp,
  output logic        outCp,
  output logic        outLm,
  output logic        outCe,
  output logic        outLi,
  output logic [7:0]  outOpcode,
  output logic [15:0] outOperand,
  output logic        outExecStart,
  output logic        outHalted,
  output logic        outFault,
  output logic [3:0]  outState
);

  localparam int cWaitW = (pMEM_WAIT_LIMIT < 1) ? 1 : $clog2(pMEM_WAIT_LIMIT + 1);

  typedef enum logic [3:0] {
    Idle   = 4'd0,
    Addr   = 4'd1,
    Inc    = 4'd2,
    Read   = 4'd3,
    Decode = 4'd4,
    OpAddr = 4'd5,
    OpInc  = 4'd6,
    OpRead = 4'd7,
    Exec   = 4'd8,
    Halt   = 4'd9,
    Fault  = 4'd10
  } stateT;

  stateT             state;
  stateT             nextState;
  logic [cWaitW-1:0] waitCount;
  logic [1:0]        remaining;
  logic              highByte;
  logic              execFirst;
  logic              waitExpired;

  assign waitExpired = (waitCount == cWaitW'(pMEM_WAIT_LIMIT));
  assign outState    = state;

  // State register plus the fetch datapath; the wait counter is cleared on the
  // INC cycle so it always starts at zero on entry to a read state.
  always_ff @(posedge inCLK) begin
    if (inRST) begin
      state      <= Idle;
      waitCount  <= '0;
      remaining  <= '0;
      highByte   <= 1'b0;
      execFirst  <= 1'b0;
      outOpcode  <= '0;
      outOperand <= '0;
    end else begin
      state     <= nextState;
      execFirst <= (nextState == Exec) && (state != Exec);
      case (state)
        Inc, OpInc: waitCount <= '0;
        Read: begin
          if (inMemReady) outOpcode <= inWbus;
          else            waitCount <= waitCount + cWaitW'(1);
        end
        OpRead: begin
          if (inMemReady) begin
            if (highByte) outOperand[15:8] <= inWbus;
            else          outOperand[7:0]  <= inWbus;
            highByte  <= 1'b1;
            remaining <= remaining - 2'd1;
          end else begin
            waitCount <= waitCount + cWaitW'(1);
          end
        end
        Decode: begin
          if (!inHaltOp) begin
            outOperand <= '0;
            highByte   <= 1'b0;
            remaining  <= (inOpBytes == 2'd3) ? 2'd2 : inOpBytes;
          end
        end
        default: ;
      endcase
    end
  end

  // A ready strobe in the last allowed wait cycle wins over the timeout.
  always_comb begin
    nextState = state;
    case (state)
      Idle:   if (inRun) nextState = Addr;
      Addr:   nextState = Inc;
      Inc:    nextState = Read;
      Read: begin
        if (inMemReady)       nextState = Decode;
        else if (waitExpired) nextState = Fault;
      end
      Decode: begin
        if (inHaltOp)                nextState = Halt;
        else if (inOpBytes == 2'd0)  nextState = Exec;
        else                         nextState = OpAddr;
      end
      OpAddr: nextState = OpInc;
      OpInc:  nextState = OpRead;
      OpRead: begin
        if (inMemReady)       nextState = (remaining == 2'd1) ? Exec : OpAddr;
        else if (waitExpired) nextState = Fault;
      end
      Exec:   if (inExecDone) nextState = inRun ? Addr : Idle;
      Halt:   nextState = Halt;
      Fault:  nextState = Fault;
      default: nextState = Idle;
    endcase
  end

  // Strobes are decoded from the state alone, except the IR load which is
  // qualified by memory ready so it pulses exactly once per opcode fetch.
  always_comb begin
    outEp        = 1'b0;
    outCp        = 1'b0;
    outLm        = 1'b0;
    outCe        = 1'b0;
    outLi        = 1'b0;
    outExecStart = 1'b0;
    outHalted    = 1'b0;
    outFault     = 1'b0;
    case (state)
      Addr, OpAddr: begin
        outEp = 1'b1;
        outLm = 1'b1;
      end
      Inc, OpInc: outCp = 1'b1;
      Read: begin
        outCe = 1'b1;
        outLi = inMemReady;
      end
      OpRead: outCe        = 1'b1;
      Exec:   outExecStart = execFirst;
      Halt:   outHalted    = 1'b1;
      Fault:  outFault     = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Randomized bench for fetch_sequencer: a reactive memory model serves bytes with
// random wait states and per-instruction expectations are computed arithmetically.
module tb_fetch_sequencer;

  localparam int cLimit = 15;

  logic        inCLK = 1'b0;
  logic        inRST;
  logic        inRun;
  logic        inMemReady;
  logic [7:0]  inWbus;
  logic [1:0]  inOpBytes;
  logic        inHaltOp;
  logic        inExecDone;
  logic        outEp, outCp, outLm, outCe, outLi;
  logic [7:0]  outOpcode;
  logic [15:0] outOperand;
  logic        outExecStart, outHalted, outFault;
  logic [3:0]  outState;

  int nChecks = 0;
  int nFails  = 0;
  int rdByte[$];
  int rdDelay[$];
  logic runHold;
  int nEp, nCp, nCe, nLi, nLm, nStart, nSamples, nOneHot;
  logic [3:0]  sState;
  logic        sHalted, sFault, sStart;
  logic [7:0]  sOpcode;
  logic [15:0] sOperand;

  fetch_sequencer #(.pMEM_WAIT_LIMIT(cLimit)) dut (
    .inCLK(inCLK), .inRST(inRST), .inRun(inRun), .inMemReady(inMemReady),
    .inWbus(inWbus), .inOpBytes(inOpBytes), .inHaltOp(inHaltOp),
    .inExecDone(inExecDone), .outEp(outEp), .outCp(outCp), .outLm(outLm),
    .outCe(outCe), .outLi(outLi), .outOpcode(outOpcode), .outOperand(outOperand),
    .outExecStart(outExecStart), .outHalted(outHalted), .outFault(outFault),
    .outState(outState)
  );

  always #5 inCLK = ~inCLK;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    if (observed !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearCounts();
    nEp = 0; nCp = 0; nCe = 0; nLi = 0; nLm = 0; nStart = 0; nSamples = 0; nOneHot = 0;
    sHalted = 1'b0; sFault = 1'b0; sStart = 1'b0;
  endtask

  // One clock: sample at the falling edge, then drive the memory reply for the
  // state entered at the rising edge.
  task automatic applyStimulus();
    @(negedge inCLK);
    nSamples++;
    nEp    += int'(outEp);
    nCp    += int'(outCp);
    nCe    += int'(outCe);
    nLi    += int'(outLi);
    nLm    += int'(outLm);
    nStart += int'(outExecStart);
    if ((int'(outEp) + int'(outCp) + int'(outCe)) > 1) nOneHot++;
    sState = outState; sOpcode = outOpcode; sOperand = outOperand;
    sHalted = outHalted; sFault = outFault; sStart = outExecStart;
    if (outCe && inMemReady && rdByte.size() > 0) begin
      void'(rdByte.pop_front());
      void'(rdDelay.pop_front());
    end
    @(posedge inCLK);
    #1;
    inMemReady = 1'b0;
    inWbus     = 8'($urandom);
    if (outCe && rdByte.size() > 0) begin
      if (rdDelay[0] == 0) begin
        inMemReady = 1'b1;
        inWbus     = 8'(rdByte[0]);
      end else begin
        rdDelay[0] = rdDelay[0] - 1;
      end
    end
    inRun = (rdByte.size() > 0) ? 1'($urandom) : runHold;
  endtask

  task automatic checkIdle(input string tag);
    @(negedge inCLK);
    checkOutput({tag, "State"}, 32'(outState), 32'd0);
    checkOutput({tag, "Strobes"},
                32'({outEp, outCp, outLm, outCe, outLi, outExecStart, outHalted, outFault}), 32'd0);
    checkOutput({tag, "Opcode"}, 32'(outOpcode), 32'h00);
    checkOutput({tag, "Operand"}, 32'(outOperand), 32'h0000);
    @(posedge inCLK);
    #1;
  endtask

  task automatic resetDut();
    inRST = 1'b1; inRun = 1'b0; inMemReady = 1'b0; inExecDone = 1'b0;
    inHaltOp = 1'b0; inOpBytes = 2'd0; runHold = 1'b0;
    @(posedge inCLK);
    @(posedge inCLK);
    #1;
    inRST = 1'b0;
    rdByte.delete();
    rdDelay.delete();
    checkIdle("reset");
  endtask

  task automatic runInstr(input int opc, input int nBytes, input bit halt,
                          input int b0, input int b1, input int d0, input int d1, input int d2,
                          input int execLen, input bit fromIdle, input bit runAfter);
    int eff, expSamples, expCe, expOperand, pre;
    bit expectFault;
    eff = halt ? 0 : ((nBytes == 3) ? 2 : nBytes);
    pre = fromIdle ? 1 : 0;
    rdByte.delete();
    rdDelay.delete();
    rdByte.push_back(opc); rdDelay.push_back(d0);
    if (eff >= 1) begin rdByte.push_back(b0); rdDelay.push_back(d1); end
    if (eff == 2) begin rdByte.push_back(b1); rdDelay.push_back(d2); end
    inOpBytes  = 2'(nBytes);
    inHaltOp   = halt;
    inExecDone = (execLen == 0);
    runHold    = runAfter;
    if (fromIdle) inRun = 1'b1;
    expectFault = (d0 > cLimit);
    expOperand  = (eff == 2) ? ((b1 << 8) | b0) : ((eff == 1) ? b0 : 0);
    expCe       = d0 + 1 + ((eff >= 1) ? d1 + 1 : 0) + ((eff == 2) ? d2 + 1 : 0);
    if (expectFault)
      expSamples = pre + 2 + (cLimit + 1) + 1;
    else if (halt)
      expSamples = pre + 2 + (d0 + 1) + 1 + 1;
    else
      expSamples = pre + 2 + (d0 + 1) + 1 + 2 * eff + ((eff >= 1) ? d1 + 1 : 0)
                   + ((eff == 2) ? d2 + 1 : 0) + 1;
    clearCounts();
    for (int k = 0; k < 400; k++) begin
      applyStimulus();
      if (sStart || sHalted || sFault) break;
    end
    checkOutput("cycles", 32'(nSamples), 32'(expSamples));
    checkOutput("oneHot", 32'(nOneHot), 32'd0);
    if (expectFault) begin
      checkOutput("faultState", 32'(sState), 32'd10);
      checkOutput("faultFlag", 32'(sFault), 32'd1);
      clearCounts();
      repeat (5) applyStimulus();
      checkOutput("faultSticky", 32'(sFault), 32'd1);
      checkOutput("faultStrobes", 32'(nEp + nCp + nCe + nLi + nLm), 32'd0);
      return;
    end
    if (halt) begin
      checkOutput("haltState", 32'(sState), 32'd9);
      checkOutput("haltOpcode", 32'(sOpcode), 32'(opc));
      clearCounts();
      repeat (20) applyStimulus();
      checkOutput("haltSticky", 32'(sHalted), 32'd1);
      checkOutput("haltNoEp", 32'(nEp), 32'd0);
      checkOutput("haltStrobes", 32'(nCp + nCe + nLi + nLm + nStart), 32'd0);
      return;
    end
    checkOutput("execState", 32'(sState), 32'd8);
    checkOutput("opcode", 32'(sOpcode), 32'(opc));
    checkOutput("operand", 32'(sOperand), 32'(expOperand));
    checkOutput("cpPulses", 32'(nCp), 32'(1 + eff));
    checkOutput("epPulses", 32'(nEp), 32'(1 + eff));
    checkOutput("lmPulses", 32'(nLm), 32'(1 + eff));
    checkOutput("liPulses", 32'(nLi), 32'd1);
    checkOutput("ceCycles", 32'(nCe), 32'(expCe));
    for (int j = 1; j <= execLen; j++) begin
      if (j == execLen) inExecDone = 1'b1;
      applyStimulus();
    end
    inExecDone = 1'b0;
    checkOutput("execStartPulses", 32'(nStart), 32'd1);
    if (!runAfter) begin
      clearCounts();
      repeat (5) applyStimulus();
      checkOutput("idleState", 32'(sState), 32'd0);
      checkOutput("idleNoEp", 32'(nEp), 32'd0);
    end
  endtask

  initial begin
    inRun = 1'b0; inMemReady = 1'b0; inWbus = 8'h00; inOpBytes = 2'd0;
    inHaltOp = 1'b0; inExecDone = 1'b0; runHold = 1'b0;
    clearCounts();
    resetDut();

    // directed opcode sequences with one- and two-byte operands
    runInstr(8'h3E, 1, 1'b0, 8'h42, 8'h00, 0, 0, 0, 1, 1'b1, 1'b1);
    runInstr(8'hC3, 2, 1'b0, 8'h34, 8'h12, 0, 0, 0, 2, 1'b0, 1'b1);
    runInstr(8'hA5, 3, 1'b0, 8'hCD, 8'hAB, 1, 2, 3, 0, 1'b0, 1'b1);
    runInstr(8'h00, 0, 1'b0, 8'h00, 8'h00, 2, 0, 0, 1, 1'b0, 1'b1);

    for (int i = 0; i < 12; i++) begin
      runInstr(int'($urandom_range(255, 0)), int'($urandom_range(3, 0)), 1'b0,
               int'($urandom_range(255, 0)), int'($urandom_range(255, 0)),
               int'($urandom_range(4, 0)), int'($urandom_range(4, 0)),
               int'($urandom_range(4, 0)), int'($urandom_range(3, 0)), 1'b0, 1'b1);
    end

    // ready arriving on the last tolerated wait cycle must not fault
    runInstr(8'h5A, 1, 1'b0, 8'h77, 8'h00, cLimit, cLimit, 0, 1, 1'b0, 1'b1);
    runInstr(8'h11, 2, 1'b0, 8'hEF, 8'hBE, 0, 1, 0, 3, 1'b0, 1'b0);

    runInstr(8'h76, 0, 1'b1, 8'h00, 8'h00, 1, 0, 0, 0, 1'b1, 1'b1);
    resetDut();

    runInstr(8'h3E, 1, 1'b0, 8'h42, 8'h00, cLimit + 1, 0, 0, 1, 1'b1, 1'b1);
    resetDut();

    // reset asserted while waiting on the high operand byte
    rdByte.delete();
    rdDelay.delete();
    rdByte.push_back(8'hC3); rdDelay.push_back(0);
    rdByte.push_back(8'h34); rdDelay.push_back(0);
    rdByte.push_back(8'h12); rdDelay.push_back(6);
    inOpBytes = 2'd2; inHaltOp = 1'b0; inExecDone = 1'b0; runHold = 1'b1; inRun = 1'b1;
    clearCounts();
    repeat (11) applyStimulus();
    checkOutput("midOpReadState", 32'(sState), 32'd7);
    checkOutput("midOpReadOperand", 32'(sOperand), 32'h0034);
    checkOutput("midOpReadOpcode", 32'(sOpcode), 32'hC3);
    inRST = 1'b1; inRun = 1'b0; runHold = 1'b0;
    @(posedge inCLK);
    #1;
    inRST = 1'b0;
    rdByte.delete();
    rdDelay.delete();
    checkIdle("opReadReset");

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
